// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule sizing, round-constant helpers and the
// forward S-box table used by both the key expander and the cipher datapath.
package aes_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  function automatic int NK(input int x);
    return 4 + 2 * x;
  endfunction

  function automatic int NR(input int x);
    return 10 + 2 * x;
  endfunction

  function automatic int NW(input int x);
    return 4 * (NR(x) + 1);
  endfunction

  // GF(2^8) multiply by 2, reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-expander bus: start/key request in, flat round-key schedule and status out.
// Vectors are ascending so bit 0 is the MSB of word 0.
interface aes_key_expander_if
  import aes_pkg::*;
#(
  parameter int X = 0
);
  logic                    start;
  logic [0:32*NK(X)-1]     key;
  logic [0:32*NW(X)-1]     words;
  logic                    busy;
  logic                    key_valid;
  logic                    done;

  modport master (output start, key, input words, busy, key_valid, done);
  modport slave  (input start, key, output words, busy, key_valid, done);
endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: forward S-box applied to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule, one 32-bit word per clock, presented as a flat
// round-key bus with round key r at bits [128*r +: 128].
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no schedule yet (after reset); waits for start
// ST_EXPAND | generating w[Nk..NW-1], one word per cycle; start ignored
// ST_DONE   | schedule complete and held; start restarts with a new key
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int X = 0
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expander_if.slave bus
);

  localparam int NK_C = NK(X);
  localparam int NW_C = NW(X);

  kx_state_e   r_state;
  kx_state_e   w_state_nxt;
  logic [5:0]  r_i;
  logic [2:0]  r_imod;
  logic [7:0]  r_rcon;
  logic        r_done;
  logic [31:0] r_w [NW_C];

  logic        w_accept;
  logic        w_last;
  logic        w_rot_step;
  logic        w_sub_step;
  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [31:0] w_rot;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_new;

  assign w_accept   = bus.start && (r_state != ST_EXPAND);
  assign w_last     = (r_i == 6'(NW_C - 1));
  assign w_rot_step = (r_imod == 3'd0);
  assign w_sub_step = (NK_C == 8) && (r_imod == 3'd4);

  assign w_prev   = r_w[r_i - 6'd1];
  assign w_back   = r_w[r_i - 6'(NK_C)];
  assign w_rot    = {w_prev[23:0], w_prev[31:24]};
  assign w_sub_in = w_rot_step ? w_rot : w_prev;

  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (w_rot_step) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    end else if (w_sub_step) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (bus.start) w_state_nxt = ST_EXPAND;
      ST_EXPAND:        if (w_last)    w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Key capture loads all Nk seed words at once; expansion writes one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i    <= '0;
      r_imod <= '0;
      r_rcon <= RCON_INIT;
      r_done <= 1'b0;
      for (int k = 0; k < NW_C; k++) begin
        r_w[k] <= '0;
      end
    end else begin
      r_done <= (r_state == ST_EXPAND) && w_last;
      if (w_accept) begin
        for (int j = 0; j < NK_C; j++) begin
          r_w[j] <= bus.key[32*j +: 32];
        end
        r_i    <= 6'(NK_C);
        r_imod <= '0;
        r_rcon <= RCON_INIT;
      end else if (r_state == ST_EXPAND) begin
        r_w[r_i] <= w_new;
        r_i      <= r_i + 6'd1;
        r_imod   <= (r_imod == 3'(NK_C - 1)) ? 3'd0 : r_imod + 3'd1;
        if (w_rot_step) begin
          r_rcon <= xtime(r_rcon);
        end
      end
    end
  end

  for (genvar g = 0; g < NW_C; g++) begin : g_words
    assign bus.words[32*g +: 32] = r_w[g];
  end

  assign bus.busy      = (r_state == ST_EXPAND);
  assign bus.key_valid = (r_state == ST_DONE);
  assign bus.done      = r_done;

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES key schedule that sits directly upstream of the decipher round datapath.
- Accepts a 128/192/256-bit cipher key and generates all round-key words, one 32-bit word per clock.
- Presents the complete schedule on a flat bus in the exact layout the decipher stage indexes: round key r occupies bits [128*r +: 128].
- Asserts key_valid once the schedule is complete; the round sequencer may start decryption only after that.

Parameters:
- x, 0, key-size select: 0 = AES-128, 1 = AES-192, 2 = AES-256.
- Derived values:
  - Nk = 4+2x
  - Nr = 10+2x
  - NW = 4*(Nr+1), i.e. 44, 52 or 60 words
  - NEXP = NW-Nk, i.e. 40, 46 or 52 cycles

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request expansion of key; sampled only in IDLE or DONE
- key  in  [0:32*Nk-1]  cipher key; bit 0 is the MSB; word j = key[32*j +: 32]
- words  out  [0:128*(2*x+11)-1]  expanded schedule; w[i] = words[32*i +: 32]
- busy  out  1  high while expansion is in progress
- key_valid  out  1  level; the schedule is complete and stable
- done  out  1  single-cycle pulse when the schedule completes

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; busy = 0, key_valid = 0, done = 0.
  - words cleared to 0; word counter i = 0; rcon = 8'h01.
  - Reset mid-expansion abandons the operation; no done pulse is produced.
- States: IDLE, EXPAND, DONE.
- IDLE or DONE with start = 1, at edge E0:
  - key is captured into w[0..Nk-1]; i = Nk; rcon = 8'h01.
  - key_valid = 0, busy = 1, state = EXPAND.
  - Words beyond Nk-1 keep stale contents until overwritten; consumers must gate on key_valid.
- EXPAND, one word per edge E1..E_NEXP:
  - temp = w[i-1]
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (multiply by 2 modulo 0x11B; 0x80 -> 0x1B -> 0x36).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; i = i+1.
- Completion, at the edge writing w[NW-1]:
  - state = DONE, busy = 0, key_valid = 1, done = 1 for exactly one cycle.
  - Latency from start edge to done-high: NEXP cycles.
- Word-level rules:
  - RotWord rotates bytes left by one.
  - SubWord applies the AES forward S-box to each of the 4 bytes.
  - Byte 0 is bits [0:7] of each word.
- start while busy: ignored; the expansion in progress is undisturbed.
- start in DONE: restarts; key_valid drops at the same edge.
- key is sampled only at E0; later key changes have no effect.
- words is held stable throughout DONE until the next start or reset.
- i mod Nk: computed with a separate modulo counter that wraps at Nk-1, not a divider.
- Only one new word is written per cycle; all others hold.

Decomposition:
- Shared package aes_pkg:
  - constants NK(x), NR(x), NW(x)
  - RCON_INIT = 8'h01
  - xtime function
  - 256-entry forward S-box table, shared with the cipher datapath
- One sub-module: aes_sub_word.
  - Purely combinational: 32-bit in, 32-bit out, four S-box lookups.
  - Instantiated once.

Test Plan:
- x=0, key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle:
  - done exactly 40 cycles later;
  - w4 = a0fafe17, w43 = b6630ca6;
  - key_valid stays high.
- x=1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 cycles;
  - w6 = fe0c91f7, w51 = 01002202.
- x=2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 cycles;
  - w8 = 9ba35411, w12 = a8b09c1a (SubWord-only step), w59 = 706c631e.
- start re-pulsed at cycle 10 of an expansion:
  - ignored; same words and done timing as the undisturbed run.
- rst asserted asynchronously mid-EXPAND, between clock edges:
  - busy, key_valid and done go 0 immediately; words all 0; no done pulse;
  - a subsequent start yields the correct schedule.
- After DONE, restart with a different key:
  - key_valid falls at the start edge;
  - the new schedule matches the FIPS-197 values;
  - done pulses exactly once.
